// File: rtl/parc_core_rob_pkg.sv
// Shared constants and requester identifiers for the ROB fill-port arbitration slice.
package parc_core_rob_pkg;

  localparam int SLOT_W    = 4;
  localparam int ROB_DEPTH = 1 << SLOT_W;
  localparam int NREQ      = 3;
  localparam int IDX_W     = 2;

  typedef enum logic [IDX_W-1:0] {
    REQ_ALU    = 2'd0,
    REQ_MULDIV = 2'd1,
    REQ_MEM    = 2'd2
  } req_id_e;

  // Round-robin successor of requester i among n requesters.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i, input int n);
    return (int'(i) == n - 1) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/parc_core_rr_arb.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module parc_core_rr_arb #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    int   cand;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/parc_core_rob_fill_arbiter.sv
// Shares the ROB fill port among writeback sources, tracks filled-but-uncommitted
// slots and raises a sticky error on a fill to a slot that is already filled.
module parc_core_rob_fill_arbiter #(
  parameter int NREQ   = parc_core_rob_pkg::NREQ,
  parameter int SLOT_W = parc_core_rob_pkg::SLOT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_val,
  input  logic [NREQ*SLOT_W-1:0] req_slot,
  output logic [NREQ-1:0]        req_rdy,
  output logic                   rob_fill_val,
  output logic [SLOT_W-1:0]      rob_fill_slot,
  output logic [1:0]             grant_id,
  input  logic                   rob_commit_wen,
  input  logic [SLOT_W-1:0]      rob_commit_slot,
  input  logic                   flush,
  output logic                   dup_fill_err
);
  import parc_core_rob_pkg::*;

  localparam int DEPTH = 1 << SLOT_W;

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  grant_id_q, grant_id_d;
  logic              fill_val_q, fill_val_d;
  logic [SLOT_W-1:0] fill_slot_q, fill_slot_d;
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic              dup_q, dup_d;

  logic [IDX_W-1:0]  win_idx;
  logic [SLOT_W-1:0] win_slot;
  logic              xfer;
  logic              commit_hit;

  // req_val/req_rdy: a transfer happens in a cycle where both are high for the
  // same requester; an ungranted requester holds req_val and req_slot stable.
  parc_core_rr_arb #(.N(NREQ), .IW(IDX_W)) u_arb (
    .req (req_val),
    .ptr (ptr_q),
    .en  (~flush),
    .gnt (req_rdy),
    .idx (win_idx)
  );

  assign xfer       = |(req_val & req_rdy);
  assign win_slot   = req_slot[win_idx*SLOT_W +: SLOT_W];
  assign commit_hit = rob_commit_wen && (rob_commit_slot == win_slot);

  always_comb begin
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    fill_val_d  = xfer;
    fill_slot_d = fill_slot_q;
    filled_d    = filled_q;
    dup_d       = dup_q;
    if (xfer) begin
      ptr_d       = next_idx(win_idx, NREQ);
      grant_id_d  = win_idx;
      fill_slot_d = win_slot;
      // A commit of the same slot this cycle means the slot is being reused.
      if (filled_q[win_slot] && !commit_hit) dup_d = 1'b1;
    end
    if (flush) begin
      filled_d = '0;
    end else begin
      if (rob_commit_wen) filled_d[rob_commit_slot] = 1'b0;
      if (xfer)           filled_d[win_slot]        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      grant_id_q  <= '0;
      fill_val_q  <= 1'b0;
      fill_slot_q <= '0;
      filled_q    <= '0;
      dup_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      fill_val_q  <= fill_val_d;
      fill_slot_q <= fill_slot_d;
      filled_q    <= filled_d;
      dup_q       <= dup_d;
    end
  end

  assign rob_fill_val  = fill_val_q;
  assign rob_fill_slot = fill_slot_q;
  assign grant_id      = grant_id_q;
  assign dup_fill_err  = dup_q;

endmodule

// File: tb/tb_parc_core_rob_fill_arbiter.sv
// Directed bench for the ROB fill arbiter with a per-cycle reference model.
module tb_parc_core_rob_fill_arbiter;

  localparam int NREQ   = 3;
  localparam int SLOT_W = 4;
  localparam int DEPTH  = 16;

  // ---------------- clock / reset ----------------
  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [NREQ-1:0]        req_val = '0;
  logic [NREQ*SLOT_W-1:0] req_slot = '0;
  logic [NREQ-1:0]        req_rdy;
  logic                   rob_fill_val;
  logic [SLOT_W-1:0]      rob_fill_slot;
  logic [1:0]             grant_id;
  logic                   rob_commit_wen = 1'b0;
  logic [SLOT_W-1:0]      rob_commit_slot = '0;
  logic                   flush = 1'b0;
  logic                   dup_fill_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  parc_core_rob_fill_arbiter #(.NREQ(NREQ), .SLOT_W(SLOT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_val         (req_val),
    .req_slot        (req_slot),
    .req_rdy         (req_rdy),
    .rob_fill_val    (rob_fill_val),
    .rob_fill_slot   (rob_fill_slot),
    .grant_id        (grant_id),
    .rob_commit_wen  (rob_commit_wen),
    .rob_commit_slot (rob_commit_slot),
    .flush           (flush),
    .dup_fill_err    (dup_fill_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int               m_ptr;
  logic [1:0]       m_gid;
  logic [SLOT_W-1:0] m_slot;
  logic [DEPTH-1:0] m_filled;
  logic             m_dup;
  logic [5:0]       exp_q[$];

  function automatic int winner(input logic [NREQ-1:0] v, input int p, input logic fl);
    if (fl) return -1;
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ptr    <= 0;
      m_gid    <= '0;
      m_slot   <= '0;
      m_filled <= '0;
      m_dup    <= 1'b0;
      exp_q.delete();
    end else begin
      int               w;
      logic [SLOT_W-1:0] s;
      logic [DEPTH-1:0] f;
      w = winner(req_val, m_ptr, flush);
      f = m_filled;
      if (flush) f = '0;
      else if (rob_commit_wen) f[rob_commit_slot] = 1'b0;
      if (w >= 0) begin
        s = req_slot[w*SLOT_W +: SLOT_W];
        if (m_filled[s] && !(rob_commit_wen && rob_commit_slot == s)) m_dup <= 1'b1;
        f[s]   = 1'b1;
        m_ptr  <= (w + 1) % NREQ;
        m_gid  <= 2'(w);
        m_slot <= s;
        exp_q.push_back({2'(w), s});
      end
      m_filled <= f;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    int         w;
    logic [2:0] er;
    logic [5:0] e;
    w  = winner(req_val, m_ptr, flush);
    er = (w >= 0) ? 3'(1 << w) : 3'b000;
    check("sb_req_rdy", req_rdy, er);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_fill_val", rob_fill_val, 1);
      check("sb_fill_slot", rob_fill_slot, e[3:0]);
      check("sb_grant_id", grant_id, e[5:4]);
    end else begin
      check("sb_fill_val", rob_fill_val, 0);
      check("sb_fill_slot", rob_fill_slot, m_slot);
      check("sb_grant_id", grant_id, m_gid);
    end
    check("sb_dup", dup_fill_err, m_dup);
    check("sb_filled", dut.filled_q, m_filled);
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] v, input logic [3:0] s0, input logic [3:0] s1,
                         input logic [3:0] s2);
    req_val  = v;
    req_slot = {s2, s1, s0};
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  // ---------------- directed stimulus ----------------
  int         t2_gid[4]  = '{0, 1, 2, 0};
  logic [3:0] t2_slot[4] = '{4'd1, 4'd2, 4'd3, 4'd1};
  logic [2:0] t2_rdy[4]  = '{3'b010, 3'b100, 3'b001, 3'b010};

  initial begin
    set_req(3'b000, 4'd0, 4'd0, 4'd0);
    repeat (2) cyc();
    check("rst_fill_val", rob_fill_val, 0);
    check("rst_fill_slot", rob_fill_slot, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_dup", dup_fill_err, 0);
    check("rst_req_rdy", req_rdy, 0);
    reset = 1'b1;

    // single ALU fill of slot 5
    set_req(3'b001, 4'd5, 4'd0, 4'd0);
    #1 check("t1_rdy", req_rdy, 3'b001);
    cyc();
    check("t1_val", rob_fill_val, 1);
    check("t1_slot", rob_fill_slot, 5);
    check("t1_gid", grant_id, 0);
    set_req(3'b000, 4'd0, 4'd0, 4'd0);
    cyc();
    check("t1_idle", rob_fill_val, 0);

    // all three valid: rotation 0,1,2,0; slot 1 is refilled on the fourth grant
    reset_pulse();
    set_req(3'b111, 4'd1, 4'd2, 4'd3);
    #1 check("t2_rdy0", req_rdy, 3'b001);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t2_val", rob_fill_val, 1);
      check("t2_slot", rob_fill_slot, t2_slot[i]);
      check("t2_gid", grant_id, t2_gid[i]);
      check("t2_rdy", req_rdy, t2_rdy[i]);
    end
    check("t2_dup", dup_fill_err, 1);
    set_req(3'b000, 4'd0, 4'd0, 4'd0);
    cyc();

    // commit between fills avoids the error; two uncommitted fills raise it
    reset_pulse();
    set_req(3'b010, 4'd0, 4'd7, 4'd0);
    cyc();
    check("t3_slot7", rob_fill_slot, 7);
    check("t3_gid1", grant_id, 1);
    set_req(3'b000, 4'd0, 4'd0, 4'd0);
    rob_commit_wen  = 1'b1;
    rob_commit_slot = 4'd7;
    cyc();
    rob_commit_wen = 1'b0;
    set_req(3'b010, 4'd0, 4'd7, 4'd0);
    cyc();
    check("t3_refill7", rob_fill_val, 1);
    check("t3_nodup7", dup_fill_err, 0);
    set_req(3'b100, 4'd0, 4'd0, 4'd9);
    cyc();
    check("t3_gid2", grant_id, 2);
    check("t3_nodup9", dup_fill_err, 0);
    cyc();
    check("t3_dup_set", dup_fill_err, 1);
    set_req(3'b000, 4'd0, 4'd0, 4'd0);
    cyc();
    check("t3_dup_sticky", dup_fill_err, 1);

    // refill of slot 4 in the same cycle it commits
    reset_pulse();
    set_req(3'b001, 4'd4, 4'd0, 4'd0);
    cyc();
    rob_commit_wen  = 1'b1;
    rob_commit_slot = 4'd4;
    cyc();
    check("t4_nodup", dup_fill_err, 0);
    check("t4_filled4", dut.filled_q[4], 1);
    rob_commit_wen = 1'b0;
    set_req(3'b000, 4'd0, 4'd0, 4'd0);
    cyc();
    check("t4_filled4_hold", dut.filled_q[4], 1);

    // flush blocks grants and clears filled; pointer holds at 1
    flush = 1'b1;
    set_req(3'b111, 4'd10, 4'd11, 4'd12);
    #1 check("t5_rdy_flush", req_rdy, 3'b000);
    cyc();
    flush = 1'b0;
    check("t5_val", rob_fill_val, 0);
    check("t5_filled", dut.filled_q, 0);
    #1 check("t5_rdy_resume", req_rdy, 3'b010);
    cyc();
    check("t5_slot", rob_fill_slot, 11);
    check("t5_gid", grant_id, 1);
    set_req(3'b000, 4'd0, 4'd0, 4'd0);
    cyc();

    // asynchronous reset while a fill is on the output
    set_req(3'b010, 4'd0, 4'd6, 4'd0);
    cyc();
    check("t6_val", rob_fill_val, 1);
    check("t6_slot", rob_fill_slot, 6);
    check("t6_gid", grant_id, 1);
    #1;
    reset = 1'b0;
    set_req(3'b000, 4'd0, 4'd0, 4'd0);
    #1;
    check("t6_rst_val", rob_fill_val, 0);
    check("t6_rst_slot", rob_fill_slot, 0);
    check("t6_rst_gid", grant_id, 0);
    check("t6_rst_dup", dup_fill_err, 0);
    check("t6_rst_filled", dut.filled_q, 0);
    cyc();
    reset = 1'b1;
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
